// File: rtl/procesos_pkg.sv
// ---------------------------------------------------------------------------
// procesos_pkg
// Shared types and constants for the procesos_sucesivos pattern sequencer.
//   phase_t    : the four successive processes run in a fixed loop
//   LEN_*      : number of steps spent in each phase
//   RESET_F    : output pattern while in reset
//   RING_SEED  : first pattern of the walking-one phase
//   last_step(): index of the final step of a given phase
// ---------------------------------------------------------------------------
package procesos_pkg;

    typedef enum logic [1:0] {
        UP   = 2'd0,
        DOWN = 2'd1,
        RING = 2'd2,
        GRAY = 2'd3
    } phase_t;

    localparam int LEN_UP   = 16;
    localparam int LEN_DOWN = 16;
    localparam int LEN_RING = 8;
    localparam int LEN_GRAY = 16;

    localparam logic [3:0] RESET_F   = 4'b0000;
    localparam logic [3:0] RING_SEED = 4'b1000;

    // Final step index of a phase; the step after it rolls into the next phase.
    function automatic logic [3:0] last_step(input phase_t ph);
        logic [3:0] idx;
        case (ph)
            UP:      idx = 4'(LEN_UP - 1);
            DOWN:    idx = 4'(LEN_DOWN - 1);
            RING:    idx = 4'(LEN_RING - 1);
            GRAY:    idx = 4'(LEN_GRAY - 1);
            default: idx = 4'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/procesos_sucesivos_bin2gray.sv
// ---------------------------------------------------------------------------
// bin2gray
// Combinational 4-bit binary to reflected Gray code converter.
//   bin_i  : binary value
//   gray_o : Gray-coded value, gray = bin ^ (bin >> 1)
// ---------------------------------------------------------------------------
module bin2gray (
    input  logic [3:0] bin_i,
    output logic [3:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/procesos_sucesivos.sv
// ---------------------------------------------------------------------------
// procesos_sucesivos
// Autonomous 4-bit pattern sequencer. Loops forever through four processes:
// count up (16), count down (16), walking one (8), Gray count (16) = 56 cycles.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (UP, step 0, F = 0000)
//   F     : registered pattern, F[0] is the MSB, F[3] the LSB
// ---------------------------------------------------------------------------
module procesos_sucesivos
    import procesos_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [0:3] F
);

    phase_t     phase_q, phase_d;
    logic [3:0] step_q,  step_d;
    logic [3:0] f_q,     f_d;
    logic [3:0] gray_s;

    // Next phase/step: advance the step, or roll into the next phase at its end.
    always_comb begin
        phase_d = UP;
        step_d  = 4'd0;
        if (step_q == last_step(phase_q)) begin
            step_d = 4'd0;
            case (phase_q)
                UP:      phase_d = DOWN;
                DOWN:    phase_d = RING;
                RING:    phase_d = GRAY;
                GRAY:    phase_d = UP;
                default: phase_d = UP;
            endcase
        end else begin
            phase_d = phase_q;
            step_d  = step_q + 4'd1;
        end
    end

    bin2gray u_bin2gray (
        .bin_i  (step_d),
        .gray_o (gray_s)
    );

    // Pattern is decoded from the next state so the output flop holds the
    // pattern of the state being loaded on the same edge (no extra latency).
    always_comb begin
        f_d = RESET_F;
        case (phase_d)
            UP:      f_d = step_d;
            DOWN:    f_d = 4'd15 - step_d;
            RING:    f_d = RING_SEED >> step_d[1:0];
            GRAY:    f_d = gray_s;
            default: f_d = RESET_F;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= UP;
            step_q  <= 4'd0;
            f_q     <= RESET_F;
        end else begin
            phase_q <= phase_d;
            step_q  <= step_d;
            f_q     <= f_d;
        end
    end

    // F[0] is the MSB, so the packed assignment maps f_q[3] onto F[0].
    assign F = f_q;

endmodule

// File: tb/tb_procesos_sucesivos.sv
// ---------------------------------------------------------------------------
// tb_procesos_sucesivos
// Directed bench for procesos_sucesivos: reset behaviour, three full loops
// against a hand-written expected table, phase-boundary table, Gray
// single-bit-change property and asynchronous mid-RING reset.
// ---------------------------------------------------------------------------
module tb_procesos_sucesivos;

    logic       clk;
    logic       rst_n;
    logic [0:3] f;

    procesos_sucesivos dut (
        .clk   (clk),
        .rst_n (rst_n),
        .F     (f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [3:0] exp_f;
    } vec_t;

    int         n_pass  = 0;
    int         n_total = 0;
    logic [3:0] exp_loop [56];
    logic [3:0] got      [57];
    vec_t       bounds   [8];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    initial begin
        logic [3:0] prev;
        // Expected F for k = 1 .. 56 (index k-1), written out by hand.
        exp_loop = '{
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
            4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF,
            4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8,
            4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0,
            4'h8, 4'h4, 4'h2, 4'h1, 4'h8, 4'h4, 4'h2, 4'h1,
            4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8,
            4'h0
        };
        bounds = '{
            '{15, 4'b1111}, '{16, 4'b1111}, '{31, 4'b0000}, '{32, 4'b1000},
            '{39, 4'b0001}, '{40, 4'b0000}, '{55, 4'b1000}, '{56, 4'b0000}
        };

        // Power-on reset, held across several edges.
        rst_n = 1'b0;
        #2;
        check("por_async", f, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("por_hold", f, 4'b0000);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Three full loops; loop 1 is also captured for the boundary table.
        prev = 4'b0000;
        for (int k = 1; k <= 168; k++) begin
            int idx;
            @(posedge clk); #1;
            idx = (k - 1) % 56;
            if (k <= 56) got[k] = f;
            check($sformatf("loop k=%0d", k), f, exp_loop[idx]);
            if (idx >= 40) begin
                n_total++;
                if ($countones(prev ^ f) == 1) n_pass++;
                else $display("FAIL gray_step k=%0d: %b -> %b, expected one bit to change",
                              k, prev, f);
            end
            prev = f;
        end

        // Phase boundaries from loop 1.
        for (int i = 0; i < 8; i++)
            check($sformatf("boundary k=%0d", bounds[i].k), got[bounds[i].k], bounds[i].exp_f);

        // Asynchronous reset with F non-zero: we are at loop start (F=0000),
        // run 5 edges to reach F=0101, then reset between edges.
        for (int i = 0; i < 5; i++) @(posedge clk);
        #1;
        check("pre_reset_running", f, 4'b0101);
        #2 rst_n = 1'b0;
        #1;
        check("reset_async", f, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset_hold", f, 4'b0000);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Mid-RING reset at k = 35.
        for (int k = 1; k <= 35; k++) begin
            @(posedge clk); #1;
        end
        check("ring_k35", f, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        check("ring_reset_async", f, 4'b0000);
        @(posedge clk); #1;
        check("ring_reset_hold", f, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("restart_k1", f, 4'b0001);
        @(posedge clk); #1;
        check("restart_k2", f, 4'b0010);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
